// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder; oversamples sclk/cs_n/mosi in the clk domain,
// shifts words MSB first and exchanges them through a tx holding register and an rx pulse.
module spi_slave #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sclk,
   input  logic                  cs_n,
   input  logic                  mosi,
   output logic                  miso,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  underrun,
   output logic                  busy
);
   localparam int W  = DATA_WIDTH;
   localparam int S  = SYNC_STAGES;
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

   state_t        state, state_nx;
   logic [S-1:0]  sclk_q, cs_q, mosi_q;
   logic [S:0]    warm;
   logic          sclk_d, cs_d, sclk_s, cs_s, mosi_s;
   logic          sclk_rise, sclk_fall, cs_fall, cs_rise, load, rx_pend, hold_full;
   logic [W-1:0]  hold, tx_shift, rx_shift, rx_next;
   logic [CW-1:0] bit_cnt;

   assign sclk_s    = sclk_q[S-1];
   assign cs_s      = cs_q[S-1];
   assign mosi_s    = mosi_q[S-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_fall   = ~cs_s & cs_d;
   assign cs_rise   = cs_s & ~cs_d;
   assign rx_next   = {rx_shift[W-2:0], mosi_s};
   assign busy      = (state == SHIFT);
   assign miso      = busy & tx_shift[W-1];
   assign tx_ready  = ~hold_full & ~rst;
   assign load      = (state == IDLE && cs_fall) ||
                      (state == SHIFT && sclk_fall && !cs_rise && bit_cnt == '0);

   // warm holds WAIT_IDLE until the synchronisers carry real pin values, not reset values
   always_comb begin
      state_nx = state;
      state_nx = (state == WAIT_IDLE) ? ((warm[S] && cs_s) ? IDLE : WAIT_IDLE)
               : (state == IDLE)      ? (cs_fall ? SHIFT : IDLE)
               :                        (cs_rise ? IDLE : SHIFT);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= WAIT_IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_q    <= '0;
         cs_q      <= '1;
         mosi_q    <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b1;
         warm      <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         tx_shift  <= '0;
         rx_shift  <= '0;
         rx_data   <= '0;
         bit_cnt   <= '0;
         rx_pend   <= 1'b0;
         rx_valid  <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         sclk_q   <= {sclk_q[S-2:0], sclk};
         cs_q     <= {cs_q[S-2:0], cs_n};
         mosi_q   <= {mosi_q[S-2:0], mosi};
         sclk_d   <= sclk_s;
         cs_d     <= cs_s;
         warm     <= {warm[S-1:0], 1'b1};
         rx_pend  <= 1'b0;
         rx_valid <= rx_pend;
         underrun <= 1'b0;
         if (state == IDLE && cs_fall) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
         end
         if (state == SHIFT && !cs_rise && sclk_rise) begin
            rx_shift <= rx_next;
            bit_cnt  <= (bit_cnt == CW'(W-1)) ? '0 : bit_cnt + 1'b1;
            if (bit_cnt == CW'(W-1)) begin
               rx_data <= rx_next;
               rx_pend <= 1'b1;
            end
         end
         if (state == SHIFT && !cs_rise && sclk_fall && bit_cnt != '0)
            tx_shift <= tx_shift << 1;
         if (load) begin
            tx_shift  <= hold_full ? hold : '0;
            underrun  <= ~hold_full;
            hold_full <= 1'b0;
         end
         // a handshake in a load cycle lands after the load, so it serves the next word
         if (tx_valid && tx_ready) begin
            hold      <= tx_data;
            hold_full <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized SPI master driving spi_slave, with a queue-based model of the
// tx holding register and an rx scoreboard checked by an independent monitor.
module tb_spi_slave;
   localparam int W    = 8;
   localparam int S    = 2;
   localparam int HALF = 4;

   logic         clk = 0, rst = 1, sclk = 0, cs_n = 1, mosi = 0, tx_valid = 0;
   logic [W-1:0] tx_data = '0;
   logic         miso, tx_ready, rx_valid, underrun, busy;
   logic [W-1:0] rx_data;

   int           tests = 0, fails = 0, und_seen = 0, und_exp = 0;
   logic [W-1:0] hold_q[$], exp_rx[$], mw[$];

   spi_slave #(.DATA_WIDTH(W), .SYNC_STAGES(S)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .underrun(underrun), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // rx scoreboard and underrun counter, sampled 1ns after each clk edge
   always @(posedge clk) begin
      #1;
      if (!rst && rx_valid) begin
         if (exp_rx.size() == 0) chk("rx_unexpected_valid", exp_rx.size(), 1);
         else chk("rx_data", rx_data, exp_rx.pop_front());
      end
      if (underrun) und_seen++;
   end

   // a word load takes the holding value if present, otherwise zero plus an underrun
   function automatic logic [W-1:0] model_load();
      if (hold_q.size() != 0) return hold_q.pop_front();
      und_exp++;
      return '0;
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic hs(input logic [W-1:0] d);
      int n = 0;
      @(negedge clk);
      while (!tx_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!tx_ready) begin
         chk("tx_ready_timeout", tx_ready, 1);
         return;
      end
      tx_valid = 1;
      tx_data  = d;
      @(posedge clk);
      #1 tx_valid = 0;
      hold_q.push_back(d);
      chk("tx_ready_after_hs", tx_ready, 0);
   endtask

   task automatic refill_at(input int n, input logic [W-1:0] d);
      wait (cs_n == 0);
      wait_clk(n);
      hs(d);
   endtask

   // sends the words in mw; the last word is cut to nlast bits
   task automatic frame(input int nlast);
      logic [W-1:0] tw, got;
      int nb;
      @(negedge clk);
      cs_n = 0;
      tw = model_load();
      wait_clk(S + 4);
      chk("busy_in_frame", busy, 1);
      for (int k = 0; k < mw.size(); k++) begin
         nb  = (k == mw.size() - 1) ? nlast : W;
         got = '0;
         for (int b = 0; b < nb; b++) begin
            mosi = mw[k][W-1-b];
            wait_clk(HALF);
            got = {got[W-2:0], miso};
            if (b == W - 1) exp_rx.push_back(mw[k]);
            sclk = 1;
            wait_clk(HALF);
            sclk = 0;
         end
         if (nb == W) begin
            chk("miso_word", got, tw);
            tw = model_load();
         end else begin
            chk("miso_partial", got, tw >> (W - nb));
         end
      end
      wait_clk(HALF);
      cs_n = 1;
      wait_clk(S + 4);
      chk("busy_after_frame", busy, 0);
      chk("underrun_count", und_seen, und_exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [W-1:0] d;
      int nw;
      wait_clk(5);
      chk("reset_tx_ready", tx_ready, 0);
      chk("reset_rx_valid", rx_valid, 0);
      chk("reset_underrun", underrun, 0);
      chk("reset_busy", busy, 0);
      chk("reset_miso", miso, 0);
      chk("reset_rx_data", rx_data, 0);
      rst = 0;
      wait_clk(S + 4);
      chk("tx_ready_after_reset", tx_ready, 1);

      // preloaded 0xA5, master sends 0x3C
      hs(8'hA5);
      mw = '{8'h3C};
      frame(W);
      chk("tx_ready_after_frame", tx_ready, 1);

      // two-word frame, holding refilled during each word so no underrun
      hs(8'h5E);
      mw = '{8'h11, 8'h22};
      d = und_exp[7:0];
      fork
         frame(W);
         begin
            refill_at(S + 4 + 3 * 2 * HALF, 8'h81);
            wait_clk(8 * 2 * HALF);
            hs(8'hC3);
         end
      join
      chk("no_underrun_two_word", und_exp[7:0], d);

      // holding empty: zero word plus underrun
      mw = '{8'h96};
      frame(W);

      // aborted after 5 bits, then a clean frame
      mw = '{8'hB7};
      frame(5);
      mw = '{8'hF0};
      frame(W);

      // reset mid-frame with cs_n held low
      hs(8'h77);
      @(negedge clk);
      cs_n = 0;
      d = model_load();
      wait_clk(S + 4);
      for (int b = 0; b < W; b++) begin
         mosi = 1'($urandom);
         wait_clk(HALF);
         if (b >= 4) chk("miso_after_rst", miso, 0);
         sclk = 1;
         wait_clk(HALF);
         sclk = 0;
         if (b == 2) begin
            rst = 1;
            wait_clk(3);
            rst = 0;
            hold_q.delete();
            und_seen = 0;
            und_exp  = 0;
         end
         if (b > 2) chk("busy_after_rst", busy, 0);
      end
      cs_n = 1;
      wait_clk(S + 4);
      hs(8'h3A);
      mw = '{8'h5A};
      frame(W);

      // handshake in the exact cycle of the cs_fall load with holding empty
      mw = '{8'h6D, 8'h92};
      fork
         frame(W);
         begin
            wait (cs_n == 0);
            repeat (S) @(posedge clk);
            #1;
            chk("tx_ready_at_load", tx_ready, 1);
            tx_valid = 1;
            tx_data  = 8'hE4;
            @(posedge clk);
            #1 tx_valid = 0;
            hold_q.push_back(8'hE4);
         end
      join

      // randomized frames
      for (int i = 0; i < 8; i++) begin
         nw = $urandom_range(1, 3);
         mw.delete();
         for (int k = 0; k < nw; k++) mw.push_back(W'($urandom));
         if ($urandom_range(0, 1) != 0) hs(W'($urandom));
         if (nw > 1 && $urandom_range(0, 1) != 0) begin
            fork
               frame(($urandom_range(0, 3) == 0) ? $urandom_range(1, W - 1) : W);
               refill_at(S + 4 + $urandom_range(2, 12) * HALF, W'($urandom));
            join
         end else begin
            frame(($urandom_range(0, 3) == 0) ? $urandom_range(1, W - 1) : W);
         end
      end

      wait_clk(10);
      chk("rx_all_delivered", exp_rx.size(), 0);
      chk("underrun_final", und_seen, und_exp);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
